// File: rtl/eda_strobe_scan_ctrl.sv
// Raster sequencer for one strobe-RAM image pass: issues each pixel to the
// evaluation datapath, writes plateau marks and moves the one-hot strobe.
// Optional build macro: EDA_STRB_SKIP_MARKED_EN (skip pixels whose strobe bit is set).
module eda_strobe_scan_ctrl #(
    parameter int M          = 4,
    parameter int N          = 4,
    parameter int I_WIDTH    = 2,
    parameter int J_WIDTH    = 2,
    parameter int ADDR_WIDTH = I_WIDTH + J_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [M-1:0][N-1:0]         strb_value,
    input  logic                        ack,
    input  logic                        mark,
    output logic                        req,
    output logic [ADDR_WIDTH-1:0]       center_addr,
    output logic [ADDR_WIDTH-1:0]       pre_center_addr,
    output logic                        clear,
    output logic                        update_strb,
    output logic                        new_pixel,
    output logic                        iterated_all,
    output logic [M-1:0]                sel_row,
    output logic [M-1:0][N-1:0]         sel_col,
    output logic                        done,
    output logic                        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_MARK,
        S_ADVANCE,
        S_FINISH
    } state_t;

    localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(M - 1);
    localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N - 1);

    state_t               state;
    state_t               state_next;
    logic [I_WIDTH-1:0]   ptr_i;
    logic [J_WIDTH-1:0]   ptr_j;
    logic [I_WIDTH-1:0]   next_i;
    logic [J_WIDTH-1:0]   next_j;
    logic                 at_last;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state           <= S_IDLE;
            ptr_i           <= '0;
            ptr_j           <= '0;
            pre_center_addr <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_CLEAR: begin
                    ptr_i <= '0;
                    ptr_j <= '0;
                end
                S_ISSUE: begin
                    if (ack && mark) begin
                        pre_center_addr <= {ptr_i, ptr_j};
                    end
                end
                S_ADVANCE: begin
                    if (!at_last) begin
                        ptr_i <= next_i;
                        ptr_j <= next_j;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef EDA_STRB_SKIP_MARKED_EN
    // Row-major find-first-zero over the strobe bits strictly after the pointer.
    always_comb begin
        int  cur;
        logic found;
        cur     = int'(ptr_i) * N + int'(ptr_j);
        found   = 1'b0;
        next_i  = '0;
        next_j  = '0;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                if (!found && ((r * N + c) > cur) && !strb_value[r][c]) begin
                    found  = 1'b1;
                    next_i = I_WIDTH'(r);
                    next_j = J_WIDTH'(c);
                end
            end
        end
        at_last = !found;
    end
`else
    logic unused_strb;
    assign unused_strb = ^strb_value;

    always_comb begin
        at_last = (ptr_i == I_LAST) && (ptr_j == J_LAST);
        next_i  = ptr_i;
        next_j  = ptr_j + 1'b1;
        if (ptr_j == J_LAST) begin
            next_i = ptr_i + 1'b1;
            next_j = '0;
        end
    end
`endif

    assign center_addr = {ptr_i, ptr_j};

    always_comb begin
        state_next   = state;
        req          = 1'b0;
        clear        = 1'b0;
        update_strb  = 1'b0;
        new_pixel    = 1'b0;
        iterated_all = 1'b0;
        sel_row      = '0;
        sel_col      = '0;
        done         = 1'b0;
        busy         = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clear      = 1'b1;
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                req = 1'b1;
                if (ack) begin
                    state_next = mark ? S_MARK : S_ADVANCE;
                end
            end
            S_MARK: begin
                new_pixel  = 1'b1;
                state_next = S_ADVANCE;
            end
            S_ADVANCE: begin
                if (at_last) begin
                    iterated_all = 1'b1;
                    state_next   = S_FINISH;
                end else begin
                    new_pixel   = 1'b1;
                    update_strb = 1'b1;
                    for (int r = 0; r < M; r++) begin
                        sel_row[r] = (next_i == I_WIDTH'(r));
                        for (int c = 0; c < N; c++) begin
                            sel_col[r][c] = (next_i == I_WIDTH'(r)) && (next_j == J_WIDTH'(c));
                        end
                    end
                    state_next = S_ISSUE;
                end
            end
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eda_strobe_scan_ctrl.sv
// Randomized self-checking bench for eda_strobe_scan_ctrl; each pass is
// predicted from the raster rules (issue order, writes, cycle totals).
module tb_eda_strobe_scan_ctrl;

    localparam int M    = 4;
    localparam int N    = 4;
    localparam int IW   = 2;
    localparam int JW   = 2;
    localparam int AW   = 4;
    localparam int NPIX = M * N;
`ifdef EDA_STRB_SKIP_MARKED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset_n;
    logic                start;
    logic [M-1:0][N-1:0] strb_value;
    logic                ack;
    logic                mark;
    logic                req;
    logic [AW-1:0]       center_addr;
    logic [AW-1:0]       pre_center_addr;
    logic                clear;
    logic                update_strb;
    logic                new_pixel;
    logic                iterated_all;
    logic [M-1:0]        sel_row;
    logic [M-1:0][N-1:0] sel_col;
    logic                done;
    logic                busy;

    int checks = 0;
    int fails  = 0;
    int wait_cyc[NPIX];
    logic [NPIX-1:0] mark_set;
    bit start_noise;

    eda_strobe_scan_ctrl #(
        .M(M), .N(N), .I_WIDTH(IW), .J_WIDTH(JW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .strb_value(strb_value),
        .ack(ack), .mark(mark), .req(req), .center_addr(center_addr),
        .pre_center_addr(pre_center_addr), .clear(clear), .update_strb(update_strb),
        .new_pixel(new_pixel), .iterated_all(iterated_all), .sel_row(sel_row),
        .sel_col(sel_col), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic string qstr(input int q[$]);
        string s;
        s = "";
        foreach (q[k]) s = {s, $sformatf("%0d ", q[k])};
        return s;
    endfunction

    // Every output packed together so "all outputs 0" is one comparison.
    function automatic logic [63:0] all_outputs();
        return 64'({req, center_addr, pre_center_addr, clear, update_strb, new_pixel,
                    iterated_all, sel_row, sel_col, done, busy});
    endfunction

    task automatic test_reset();
        start = 1'b1; ack = 1'b1; mark = 1'b1; strb_value = '0;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_outputs() !== 64'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", all_outputs());
        end
        start = 1'b0; ack = 1'b0; mark = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    // Drives one pass with the current wait/mark/strobe settings and compares it to the model.
    task automatic run_pass(input string name);
        int exp_issue[$], exp_moves[$], exp_marks[$];
        int got_issue[$], got_moves[$], got_marks[$];
        int req_cnt[NPIX];
        int exp_done, done_cyc, iter_cyc, iter_cnt, first_req, cyc, p, q, a, row, col;
        bit bad_overlap, bad_busy, bad_clear, bad_wait;
        logic prev_req;
        logic [NPIX-1:0] strb_flat;

        strb_flat = strb_value;
        exp_issue.push_back(0);
        p = 0;
        while (1) begin
            q = -1;
            for (int k = p + 1; k < NPIX; k++) begin
                if (q < 0 && (!SKIP || !strb_flat[k])) q = k;
            end
            if (q < 0) break;
            exp_issue.push_back(q);
            exp_moves.push_back(q);
            p = q;
        end
        exp_done = 2;
        foreach (exp_issue[k]) begin
            exp_done += 2 + wait_cyc[exp_issue[k]] + int'(mark_set[exp_issue[k]]);
            if (mark_set[exp_issue[k]]) exp_marks.push_back(exp_issue[k]);
        end

        foreach (req_cnt[k]) req_cnt[k] = 0;
        done_cyc = -1; iter_cyc = -1; iter_cnt = 0; first_req = -1; cyc = 0;
        bad_overlap = 0; bad_busy = 0; bad_clear = 0; bad_wait = 0; prev_req = 0;

        @(negedge clk);
        start = 1'b1;
        while (cyc < 500 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start = start_noise ? 1'($urandom_range(1)) : 1'b0;
            if (clear !== (cyc == 1)) bad_clear = 1;
            if (busy !== 1'b1) bad_busy = 1;
            if (req === 1'b1) begin
                a = int'(center_addr);
                if (first_req < 0) first_req = cyc;
                if (!prev_req) got_issue.push_back(a);
                req_cnt[a]++;
                ack  = (req_cnt[a] >= wait_cyc[a] + 1);
                mark = ack ? mark_set[a] : 1'($urandom_range(1));
            end else begin
                ack  = 1'($urandom_range(1));
                mark = 1'($urandom_range(1));
            end
            prev_req = req;
            if (new_pixel && update_strb) begin
                row = -1; col = -1;
                for (int r = 0; r < M; r++) begin
                    if (sel_row[r]) row = r;
                    for (int c = 0; c < N; c++) if (sel_col[r][c]) col = c;
                end
                if ($countones(sel_row) != 1 || $countones(sel_col) != 1 || row < 0 ||
                    sel_col[row] == '0)
                    got_moves.push_back(-1);
                else
                    got_moves.push_back(row * N + col);
            end
            if (new_pixel && !update_strb) got_marks.push_back(int'(pre_center_addr));
            if (new_pixel && (clear || iterated_all)) bad_overlap = 1;
            if (iterated_all) begin
                iter_cnt++;
                iter_cyc = cyc;
            end
            if (done) done_cyc = cyc;
        end
        start = 1'b0; ack = 1'b0; mark = 1'b0;

        foreach (exp_issue[k]) if (req_cnt[exp_issue[k]] != wait_cyc[exp_issue[k]] + 1) bad_wait = 1;

        checks++;
        if (done_cyc != exp_done) begin
            fails++;
            $display("[TB] FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
        end
        checks++;
        if (iter_cyc != exp_done - 1 || iter_cnt != 1) begin
            fails++;
            $display("[TB] FAIL %s iterated_all: got cycle %0d count %0d expected cycle %0d count 1",
                     name, iter_cyc, iter_cnt, exp_done - 1);
        end
        checks++;
        if (first_req != 2) begin
            fails++;
            $display("[TB] FAIL %s first_req_cycle: got %0d expected 2", name, first_req);
        end
        checks++;
        if (qstr(got_issue) != qstr(exp_issue)) begin
            fails++;
            $display("[TB] FAIL %s issue_order: got %s expected %s", name, qstr(got_issue), qstr(exp_issue));
        end
        checks++;
        if (qstr(got_moves) != qstr(exp_moves)) begin
            fails++;
            $display("[TB] FAIL %s strobe_moves: got %s expected %s", name, qstr(got_moves), qstr(exp_moves));
        end
        checks++;
        if (qstr(got_marks) != qstr(exp_marks)) begin
            fails++;
            $display("[TB] FAIL %s mark_writes: got %s expected %s", name, qstr(got_marks), qstr(exp_marks));
        end
        checks++;
        if ({bad_clear, bad_busy, bad_overlap, bad_wait} != 4'b0000) begin
            fails++;
            $display("[TB] FAIL %s flags(clear,busy,overlap,req_hold): got %b expected 0000",
                     name, {bad_clear, bad_busy, bad_overlap, bad_wait});
        end
        @(negedge clk);
        checks++;
        if ({done, busy, req} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL %s post_pass_idle: got done,busy,req=%b expected 000", name, {done, busy, req});
        end
    endtask

    task automatic set_defaults();
        foreach (wait_cyc[k]) wait_cyc[k] = 0;
        mark_set    = '0;
        strb_value  = '0;
        start_noise = 1'b0;
    endtask

    task automatic test_plain_pass();
        set_defaults();
        run_pass("plain");
    endtask

    task automatic test_mark();
        set_defaults();
        mark_set = NPIX'(1) << 5;
        run_pass("mark5");
    endtask

    task automatic test_ack_delay();
        set_defaults();
        wait_cyc[3] = 3;
        run_pass("ack_delay3");
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit hit;
        set_defaults();
        wait_cyc[7] = 1000;
        hit = 0; cyc = 0;
        @(negedge clk);
        start = 1'b1;
        while (cyc < 200 && !hit) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (req === 1'b1 && center_addr == AW'(7)) begin
                hit = 1;
                ack = 1'b0;
                reset_n = 1'b1;
            end else begin
                ack = 1'b1; mark = 1'b0;
            end
        end
        checks++;
        if (!hit) begin
            fails++;
            $display("[TB] FAIL reset_mid_reach7: got no req on addr 7 expected one within 200 cycles");
        end
        @(negedge clk);
        checks++;
        if (all_outputs() !== 64'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid_outputs: got %h expected 0", all_outputs());
        end
        reset_n = 1'b0; ack = 1'b0;
        wait_cyc[7] = 0;
        run_pass("after_reset");
    endtask

    task automatic test_start_while_busy();
        set_defaults();
        start_noise = 1'b1;
        wait_cyc[9] = 2;
        run_pass("start_busy");
    endtask

    task automatic test_skip_marked();
        set_defaults();
        for (int k = 1; k <= 14; k++) strb_value[k / N][k % N] = 1'b1;
        run_pass("skip_1_14");
    endtask

    task automatic test_random();
        for (int t = 0; t < 5; t++) begin
            foreach (wait_cyc[k]) wait_cyc[k] = $urandom_range(2);
            mark_set    = NPIX'($urandom);
            strb_value  = (M * N)'($urandom);
            start_noise = 1'($urandom_range(1));
            run_pass($sformatf("random%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_plain_pass();
        test_mark();
        test_ack_delay();
        test_reset_mid();
        test_start_while_busy();
        test_skip_marked();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/eda_strobe_scan_ctrl.md
# eda_strobe_scan_ctrl

- Sequencer that drives the strobe RAM through one full image pass.
- Steps a raster pointer over all M×N pixels and presents each pixel to the neighbourhood-evaluation datapath with a req/ack handshake.
- Marks plateau pixels via the pre-centre write path, then moves the strobe to the next pixel with a one-hot `sel_row`/`sel_col` update.
- Sits between the top-level start/done control and the strobe RAM + comparator datapath.

## Interface

Parameters:
- `M`, `CFG_M`: image rows.
- `N`, `CFG_N`: image columns.
- `I_WIDTH`, `CFG_I_WIDTH`: row index width.
- `J_WIDTH`, `CFG_J_WIDTH`: column index width.
- `ADDR_WIDTH`, `CFG_ADDR_WIDTH`: equals `I_WIDTH + J_WIDTH`; addr = {i, j}.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `reset_n`  in  1  synchronous reset, active-high (1 = reset), sampled on `clk` rising edge.
- `start`  in  1  begin pass; sampled only in IDLE.
- `strb_value`  in  [M-1:0][N-1:0]  strobe RAM contents.
- `ack`  in  1  datapath finished evaluating `center_addr`.
- `mark`  in  1  qualified by `ack`: pixel belongs to a maximal plateau.
- `req`  out  1  pixel presented to datapath.
- `center_addr`  out  ADDR_WIDTH  current pixel {i, j}.
- `pre_center_addr`  out  ADDR_WIDTH  pixel being marked.
- `clear`  out  1  strobe RAM clear.
- `update_strb`  out  1  strobe move (1) vs. mark write (0).
- `new_pixel`  out  1  strobe RAM write enable.
- `iterated_all`  out  1  last pixel processed.
- `sel_row`  out  M  one-hot next row.
- `sel_col`  out  [M-1:0][N-1:0]  one-hot next column, valid in the selected row only; all other rows zero.
- `done`  out  1  one-cycle pass-complete pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation

- All outputs are registered or state-decoded (Moore). Reset value of every output is 0. The pointer resets to (0,0) and the state to IDLE.
- IDLE → CLEAR on `start`. `start` in any other state is ignored.
- CLEAR (1 cycle): `clear=1`; pointer ← (0,0). Next state ISSUE.
- ISSUE:
  - `req=1`; `center_addr={i,j}` held stable.
  - Stay in ISSUE until `ack=1`.
  - On `ack`: if `mark=1` latch `pre_center_addr←{i,j}` and go to MARK; otherwise go to ADVANCE.
  - `req` drops the cycle after `ack`.
- MARK (1 cycle): `new_pixel=1`, `update_strb=0`, `pre_center_addr` valid. Next state ADVANCE.
- ADVANCE (1 cycle):
  - If the pointer is (M-1, N-1): `iterated_all=1`, `new_pixel=0`, next state FINISH.
  - Otherwise compute the next pixel:
    - j+1 if j<N-1;
    - else (i+1, 0), i.e. column wrap increments the row.
  - Drive `new_pixel=1`, `update_strb=1`, `sel_row[i']=1`, `sel_col[i'][j']=1`. Update the pointer; next state ISSUE.
- FINISH (1 cycle): `done=1`. Next state IDLE.
- `mark` is ignored when `ack=0`. `ack` is ignored outside ISSUE.
- Reset asserted in any state, mid-handshake included: next cycle IDLE, all outputs 0, no write strobes.
- Index arithmetic is unsigned, with `i` zero-extended to `I_WIDTH` and `j` to `J_WIDTH`. Out-of-range indices are never produced.

## Timing

- Cycle numbering: `start` sampled at edge k. `clear=1` during cycle k+1. First `req=1`, with `center_addr=0`, during cycle k+2.
- Per pixel, with `ack` in the first ISSUE cycle:
  - 2 cycles unmarked (ISSUE, ADVANCE);
  - 3 cycles marked (ISSUE, MARK, ADVANCE).
- Full unmarked pass: `done` is high in cycle k+2+2·M·N. `iterated_all` is high in the cycle before it.
- Each `ack` wait cycle adds 1 cycle.
- `new_pixel` never asserts together with `clear` or `iterated_all`.

## Configuration

- `EDA_STRB_SKIP_MARKED_EN` defined: ADVANCE selects the next raster pixel after the pointer whose `strb_value` bit is 0, via a priority find-first-zero (row-major).
  - If none remain: `iterated_all=1` and go to FINISH.
  - Already-marked pixels are never re-issued.
- Undefined: strict raster order; `strb_value` is unused.

## Test plan

- M=N=4, `ack` tied 1, `mark` 0: `start` → `clear` at k+1, 16 `req` pulses with addr 0..15, `done` at k+34, 15 `update_strb` writes, no mark writes.
- M=N=4, `mark=1` on addr 5 only: exactly one cycle with `new_pixel=1`, `update_strb=0`, `pre_center_addr=5`; `done` at k+35.
- `ack` delayed 3 cycles on addr 3: `req` and `center_addr=3` held 4 cycles; `sel_row=0010`, `sel_col[1]=0001` issued after the `ack`.
- Reset asserted while `req=1` on addr 7: next cycle all outputs 0, `busy=0`; new `start` restarts from addr 0 with `clear`.
- `start` pulsed while busy: ignored, exactly one `done`.
- `EDA_STRB_SKIP_MARKED_EN`, `strb_value` bits 1–14 set, pointer 0: ADVANCE jumps to addr 15, then `iterated_all` and `done`.
